// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
// Applies redirect > stall > memory-wait > advance each cycle and keeps saturating debug counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      inst,
  output logic [31:0]      IF_ID_inst,
  output logic [31:0]      IF_ID_pc4,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ActAdvance,
    ActWait,
    ActStall,
    ActRedirect
  } action_e;

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  action_e          w_action;
  logic [31:0]      r_pc, w_pc_d, w_pc4;
  logic [31:0]      r_if_id_inst, w_if_id_inst_d;
  logic [31:0]      r_if_id_pc4, w_if_id_pc4_d;
  logic [CNT_W-1:0] r_stall_cnt, w_stall_cnt_d;
  logic [CNT_W-1:0] r_flush_cnt, w_flush_cnt_d;

  assign w_pc4     = r_pc + 32'd4;
  assign imem_addr = r_pc;
  // An invalid fetch reads as the all-zero NOP so the hazard unit never sees garbage.
  assign inst      = imem_ready ? imem_rdata : 32'd0;

  always_comb begin
    w_action = ActAdvance;
    if (redirect) begin
      w_action = ActRedirect;
    end else if (stall) begin
      w_action = ActStall;
    end else if (!imem_ready) begin
      w_action = ActWait;
    end
  end

  always_comb begin
    w_pc_d         = r_pc;
    w_if_id_inst_d = 32'd0;
    w_if_id_pc4_d  = 32'd0;
    w_stall_cnt_d  = r_stall_cnt;
    w_flush_cnt_d  = r_flush_cnt;
    unique case (w_action)
      ActRedirect: begin
        w_pc_d = {redirect_pc[31:2], 2'b00};
        if (!(&r_flush_cnt)) begin
          w_flush_cnt_d = r_flush_cnt + CNT_W'(1);
        end
      end
      ActStall: begin
        if (!(&r_stall_cnt)) begin
          w_stall_cnt_d = r_stall_cnt + CNT_W'(1);
        end
      end
      ActWait: begin
      end
      ActAdvance: begin
        w_pc_d         = w_pc4;
        w_if_id_inst_d = imem_rdata;
        w_if_id_pc4_d  = w_pc4;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= ResetPcAligned;
      r_if_id_inst <= 32'd0;
      r_if_id_pc4  <= 32'd0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_pc         <= w_pc_d;
      r_if_id_inst <= w_if_id_inst_d;
      r_if_id_pc4  <= w_if_id_pc4_d;
      r_stall_cnt  <= w_stall_cnt_d;
      r_flush_cnt  <= w_flush_cnt_d;
    end
  end

  assign IF_ID_inst = r_if_id_inst;
  assign IF_ID_pc4  = r_if_id_pc4;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic against a cycle-level model.
// A second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, imem_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata, inst, if_id_inst, if_id_pc4;
  logic [15:0] stall_cnt, flush_cnt;
  logic [31:0] imem_addr_s, inst_s, if_id_inst_s, if_id_pc4_s;
  logic [1:0]  stall_cnt_s, flush_cnt_s;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] m_pc, m_inst, m_pc4;
  int          m_nstall, m_nflush;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(.RESET_PC(32'h0), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready), .inst(inst),
    .IF_ID_inst(if_id_inst), .IF_ID_pc4(if_id_pc4), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  fetch_stage #(.RESET_PC(32'h0), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr_s), .imem_rdata(imem_rdata), .imem_ready(imem_ready), .inst(inst_s),
    .IF_ID_inst(if_id_inst_s), .IF_ID_pc4(if_id_pc4_s), .stall_cnt(stall_cnt_s),
    .flush_cnt(flush_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input int n, input int max);
    return (n > max) ? 32'(max) : 32'(n);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_nstall = 0; m_nflush = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".addr"}, imem_addr, m_pc);
    check({tag, ".if_inst"}, if_id_inst, m_inst);
    check({tag, ".if_pc4"}, if_id_pc4, m_pc4);
    check({tag, ".scnt"}, 32'(stall_cnt), sat(m_nstall, 65535));
    check({tag, ".fcnt"}, 32'(flush_cnt), sat(m_nflush, 65535));
    check({tag, ".addr2"}, imem_addr_s, m_pc);
    check({tag, ".scnt2"}, 32'(stall_cnt_s), sat(m_nstall, 3));
    check({tag, ".fcnt2"}, 32'(flush_cnt_s), sat(m_nflush, 3));
  endtask

  // Called 1 time unit after a rising edge: drive, check comb outputs, clock, check state.
  task automatic cycle(input string tag, input logic st, input logic rd,
                       input logic [31:0] rpc, input logic rdy);
    stall = st; redirect = rd; redirect_pc = rpc; imem_ready = rdy;
    #1;
    check({tag, ".inst"}, inst, rdy ? mem_word(m_pc) : 32'h0);
    if (rd) begin
      m_pc = {rpc[31:2], 2'b00}; m_inst = 0; m_pc4 = 0; m_nflush++;
    end else if (st) begin
      m_inst = 0; m_pc4 = 0; m_nstall++;
    end else if (!rdy) begin
      m_inst = 0; m_pc4 = 0;
    end else begin
      m_inst = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_state("reset");
    rst_n = 1'b1;

    // Sequential fetch from 0
    for (int i = 0; i < 4; i++) cycle("adv", 1'b0, 1'b0, 32'h0, 1'b1);
    // Load-use stall at 0x10
    cycle("to10", 1'b0, 1'b1, 32'h10, 1'b1);
    cycle("stall", 1'b1, 1'b0, 32'h0, 1'b1);
    cycle("resume", 1'b0, 1'b0, 32'h0, 1'b1);
    // Redirect beats stall, target alignment
    cycle("rdst", 1'b1, 1'b1, 32'h203, 1'b1);
    // Memory wait at 0x40
    cycle("to40", 1'b0, 1'b1, 32'h40, 1'b1);
    for (int i = 0; i < 3; i++) cycle("wait", 1'b0, 1'b0, 32'h0, 1'b0);
    cycle("ready", 1'b0, 1'b0, 32'h0, 1'b1);
    // PC wrap
    cycle("toend", 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    cycle("wrap", 1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap.pc0", imem_addr, 32'h0);
    // Saturation of the 2-bit counters
    for (int i = 0; i < 5; i++) cycle("sat", 1'b1, 1'b0, 32'h0, 1'b1);
    check("sat.scnt2_3", 32'(stall_cnt_s), 32'd3);
    for (int i = 0; i < 4; i++) cycle("fsat", 1'b0, 1'b1, 32'h100, 1'b1);

    // Async reset between edges while stalling
    stall = 1'b1; redirect = 1'b0; imem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.addr", imem_addr, 32'h0);
    check("arst.if_inst", if_id_inst, 32'h0);
    check("arst.scnt", 32'(stall_cnt), 32'h0);
    check("arst.fcnt", 32'(flush_cnt), 32'h0);
    @(posedge clk);
    #1;
    check_state("arst_hold");
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic        st, rd, rdy;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                        : $urandom;
      cycle("rand", st, rd, rpc, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC, drives the instruction-memory address and exposes the current fetch word as `inst`.
- Latches `IF_ID_inst`/`IF_ID_pc4` for decode.
- Consumes the hazard unit's `stall` and the EX/MEM branch/jump `redirect`; keeps saturating stall/flush event counters for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  load-use stall request from hazard unit
- redirect  input  1  taken branch/jump; PC must be replaced
- redirect_pc  input  32  branch/jump target
- imem_addr  output  32  instruction-memory address (= PC)
- imem_rdata  input  32  instruction word at imem_addr, combinational
- imem_ready  input  1  imem_rdata valid this cycle
- inst  output  32  fetch-stage instruction to hazard unit
- IF_ID_inst  output  32  IF/ID registered instruction
- IF_ID_pc4  output  32  IF/ID registered PC+4
- stall_cnt  output  CNT_W  saturating count of stall cycles
- flush_cnt  output  CNT_W  saturating count of redirect cycles

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately):
  - PC=RESET_PC, IF_ID_inst=32'd0, IF_ID_pc4=32'd0, stall_cnt=0, flush_cnt=0.
  - Outputs are valid during reset: imem_addr=RESET_PC; inst follows its combinational rule.
  - Reset asserted mid-stall or mid-redirect discards all state; no pending action survives reset.
- Combinational outputs:
  - imem_addr = PC.
  - inst = imem_ready ? imem_rdata : 32'd0. The all-zero word is the bubble/NOP, so the hazard unit never stalls on an invalid fetch.
- Per-cycle update, priority redirect > stall > not-ready > advance:
  - REDIRECT (redirect=1): PC <= {redirect_pc[31:2],2'b00}; IF_ID_inst <= 0; IF_ID_pc4 <= 0; flush_cnt++ (saturating). The stall input is ignored this cycle and stall_cnt does not increment.
  - STALL (redirect=0, stall=1): PC holds; IF_ID_inst <= 0 (bubble lets the load in decode advance while the dependent instruction is refetched); IF_ID_pc4 <= 0; stall_cnt++ (saturating).
  - WAIT (redirect=0, stall=0, imem_ready=0): PC holds; IF_ID_inst <= 0; IF_ID_pc4 <= 0; no counter change.
  - ADVANCE (otherwise): PC <= PC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); IF_ID_inst <= imem_rdata; IF_ID_pc4 <= PC+4.
- Latencies:
  - Fetch word appears on IF_ID_inst 1 cycle after its ADVANCE edge.
  - Redirect target appears on imem_addr 1 cycle after redirect is sampled.
  - A back-to-back stall holds the same PC for N cycles and inserts N bubbles.
- Counters:
  - Unsigned, CNT_W bits, saturate at all-ones; no wrap.
  - Registered; the value is visible the cycle after the event.
- PC bits [1:0] are always 0.
- No X propagation: all registers are reset; outputs are defined from reset assertion onward.

Test Plan:
- Reset/advance: RESET_PC=0, imem_ready=1, imem_rdata=PC-indexed words, hold rst_n=0 then release -> imem_addr 0,4,8,12 on successive cycles; IF_ID_inst equals word@0 one cycle after first edge; IF_ID_pc4=4.
- Load-use stall: PC=0x10, stall=1 for 1 cycle -> PC stays 0x10 for one extra cycle; IF_ID_inst=0 the next cycle; stall_cnt=1; then resumes 0x14.
- Redirect beats stall: stall=1 and redirect=1 with redirect_pc=0x203 simultaneously -> next imem_addr=0x200; IF_ID_inst=0; flush_cnt=1; stall_cnt unchanged.
- Memory wait: imem_ready=0 for 3 cycles at PC=0x40 -> inst=0; IF_ID_inst=0 for 3 cycles; PC stays 0x40; counters unchanged; ready=1 -> PC 0x44.
- Wrap and saturation: CNT_W=2, PC forced via redirect to 0xFFFF_FFFC, advance -> PC=0; 5 consecutive stalls -> stall_cnt=3.
- Async reset mid-stall: rst_n falls between clock edges while stall=1 -> imem_addr=RESET_PC immediately; IF_ID_inst=0; counters 0.
